sigmoid_scheduler: RTL and testbench
====================================

Name: sigmoid_scheduler

Overview:
- Shares one combinational Sigmoid_Calculator instance between NUM_REQ requesters, e.g. hidden-layer and output-layer neuron engines in the back-propagation datapath.
- Arbitrates round-robin and registers the operand for a fixed multi-cycle window, which covers the long multiply/divide path.
- Returns F_net tagged with the requester id over a valid/ready handshake.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- ID_W, 2: width of the id tag; must be at least clog2(NUM_REQ).
- CALC_CYCLES, 4: clock cycles the operand is held before the result is captured (1..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_net  in  16*NUM_REQ  signed Net operands; requester i uses bits [16i+15:16i].
- req_ready  out  NUM_REQ  one-hot grant/accept.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_fnet  out  32  signed F_net, scaled by 1000.
- rsp_id  out  ID_W  index of the requester that owns rsp_fnet.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: state IDLE, req_ready=0, rsp_valid=0, rsp_fnet=0, rsp_id=0, busy=0, rr pointer=0, counter=0, net_q=0.
- A reset asserted mid-operation aborts the operation. The in-flight result is discarded and is never presented.
- States: IDLE, CALC, RESP.
- IDLE, arbitration:
  - Pick the first asserted req_valid searching from index ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only for the winner g, and only in IDLE. req_ready is combinational from req_valid and ptr.
  - If no req_valid is asserted, req_ready=0 and the block stays in IDLE.
- IDLE, accept (on the edge where req_valid[g] and req_ready[g] are both high):
  - net_q <= req_net[g]; id_q <= g; ptr <= (g+1) mod NUM_REQ; cnt <= CALC_CYCLES-1; state -> CALC.
- CALC:
  - net_q drives Sigmoid_Calculator.Net and does not change while in CALC.
  - cnt decrements each cycle.
  - On the edge where cnt==0: rsp_fnet <= F_net, rsp_id <= id_q, rsp_valid <= 1, state -> RESP.
  - rsp_valid rises exactly CALC_CYCLES edges after the accept edge.
- RESP:
  - rsp_valid, rsp_fnet and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that handshake edge: rsp_valid <= 0, state -> IDLE.
  - No new request is accepted in CALC or RESP, so the minimum spacing between accepts is CALC_CYCLES+2 cycles.
  - If rsp_ready is already high when RESP is entered, RESP lasts 1 cycle.
- Arithmetic, matching the existing unit bit-exactly:
  - X = Net*1000 (32-bit signed).
  - Y = X / (|Net|+1000), truncated toward zero.
  - F = (Y+1000)/2, truncated toward zero.
  - Output range is 15..985 over the full 16-bit input range.
- Requester rules:
  - A requester must hold req_valid and req_net stable until it is granted.
  - Deasserting req_valid before the grant is legal; that request is simply not served.
- Fairness: with all requesters permanently valid, grants rotate 0,1,2,...,NUM_REQ-1,0,...
- Simultaneous events: a new req_valid arriving during CALC or RESP waits. It is arbitrated in the first IDLE cycle.

Decomposition:
- Shared package sigmoid_pkg holds:
  - SIG_SCALE=1000, NET_W=16, FNET_W=32.
  - State enum {S_IDLE, S_CALC, S_RESP}.
- Sub-module rr_arbiter (NUM_REQ): inputs req and ptr; outputs one-hot grant and encoded index. It is purely combinational.
- Sigmoid_Calculator is instantiated unchanged; its X, Y and Z outputs are left unconnected.

Test Plan:
- Single request: req 0 with Net=0, CALC_CYCLES=4, rsp_ready=1 -> rsp_valid rises 4 edges after accept with rsp_fnet=500, rsp_id=0; busy low again 1 cycle later.
- Value sweep on req 1: Net=1000 -> 750; Net=-1000 -> 250; Net=32767 -> 985; Net=-32768 -> 15; Net=3000 -> 875 -> each result exact and tagged id=1.
- Round-robin: all 4 requesters valid continuously with Net=i*100 -> grant order 0,1,2,3,0; results 500,545,583,615 tagged 0,1,2,3.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_fnet and rsp_id stable; no req_ready asserted; the next grant comes the cycle after the handshake.
- Reset mid-CALC: assert rst 2 cycles after accept -> all outputs 0 immediately; no rsp_valid after release; the next request is served from ptr=0.
- CALC_CYCLES=1 and the requester drops req_valid before grant -> a 1-cycle CALC; the dropped requester receives no response.

Source files
------------

// File: rtl/sigmoid_pkg.sv
// Shared constants and FSM state type for the sigmoid scheduler.
package sigmoid_pkg;

   localparam int SIG_SCALE = 1000;
   localparam int NET_W     = 16;
   localparam int FNET_W    = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_RESP = 2'd2
   } sched_state_e;

endpackage

// File: rtl/Sigmoid_Calculator.sv
// Combinational sigmoid approximation: F = ((Net*1000)/(|Net|+1000) + 1000) / 2.
// All divisions are signed and truncate toward zero.
module Sigmoid_Calculator (
   input  logic signed [15:0] Net,
   output logic signed [31:0] X,
   output logic signed [31:0] Y,
   output logic signed [31:0] Z,
   output logic signed [31:0] F_net
);

   logic signed [31:0] net_ext;
   logic signed [31:0] mag;

   // Widen before taking the magnitude so -32768 does not overflow.
   always_comb begin
      net_ext = 32'(Net);
      mag     = (net_ext < 0) ? -net_ext : net_ext;
      X       = net_ext * 32'sd1000;
      Y       = X / (mag + 32'sd1000);
      Z       = Y + 32'sd1000;
      F_net   = Z / 32'sd2;
   end

endmodule

// File: rtl/sigmoid_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   idx
);

   // Scan NUM_REQ positions starting at ptr; the first hit wins.
   always_comb begin
      int  j;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/sigmoid_scheduler.sv
// Shares one Sigmoid_Calculator among NUM_REQ requesters. The winner's operand
// is held for CALC_CYCLES cycles, then the result is returned tagged with its id.
module sigmoid_scheduler
   import sigmoid_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int CALC_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NET_W*NUM_REQ-1:0]    req_net,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic signed [FNET_W-1:0]    rsp_fnet,
   output logic [ID_W-1:0]             rsp_id,
   output logic                        busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_e              state_q, state_d;
   logic [PTR_W-1:0]          ptr_q, ptr_d;
   logic [7:0]                cnt_q, cnt_d;
   logic signed [NET_W-1:0]   net_q, net_d;
   logic [ID_W-1:0]           id_q, id_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic signed [FNET_W-1:0]  rsp_fnet_q, rsp_fnet_d;
   logic [ID_W-1:0]           rsp_id_q, rsp_id_d;

   logic [NUM_REQ-1:0]        grant;
   logic [PTR_W-1:0]          grant_idx;
   logic signed [FNET_W-1:0]  f_net;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (grant_idx)
   );

   // The registered operand keeps the long multiply/divide path stable during CALC.
   Sigmoid_Calculator u_calc (
      .Net   (net_q),
      .X     (),
      .Y     (),
      .Z     (),
      .F_net (f_net)
   );

   // Grants are only offered while idle; a request arriving later waits for IDLE.
   assign req_ready = (state_q == S_IDLE) ? grant : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_fnet  = rsp_fnet_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != S_IDLE);

   // Next-state and datapath update for IDLE -> CALC -> RESP.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      net_d       = net_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_fnet_d  = rsp_fnet_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         S_IDLE: begin
            if (|grant) begin
               net_d   = req_net[int'(grant_idx)*NET_W +: NET_W];
               id_d    = ID_W'(grant_idx);
               ptr_d   = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
               cnt_d   = 8'(CALC_CYCLES-1);
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_q == 8'd0) begin
               rsp_fnet_d  = f_net;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset drops any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         net_q       <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_fnet_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         net_q       <= net_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_fnet_q  <= rsp_fnet_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

endmodule

// File: tb/tb_sigmoid_scheduler.sv
// Directed bench for sigmoid_scheduler: a CALC_CYCLES=4 instance for the main
// flows and a CALC_CYCLES=1 instance for the short-window / dropped-request case.
module tb_sigmoid_scheduler;

   logic              clk = 1'b0;
   logic              rst = 1'b0;

   logic [3:0]        req_valid = '0;
   logic [63:0]       req_net   = '0;
   logic [3:0]        req_ready;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic signed [31:0] rsp_fnet;
   logic [1:0]        rsp_id;
   logic              busy;

   logic [3:0]        req_valid1 = '0;
   logic [63:0]       req_net1   = '0;
   logic [3:0]        req_ready1;
   logic              rsp_valid1;
   logic              rsp_ready1 = 1'b1;
   logic signed [31:0] rsp_fnet1;
   logic [1:0]        rsp_id1;
   logic              busy1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sigmoid_scheduler #(.NUM_REQ(4), .ID_W(2), .CALC_CYCLES(4)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_net(req_net),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_fnet(rsp_fnet), .rsp_id(rsp_id), .busy(busy)
   );

   sigmoid_scheduler #(.NUM_REQ(4), .ID_W(2), .CALC_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_net(req_net1),
      .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_fnet(rsp_fnet1), .rsp_id(rsp_id1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Advance one edge and settle 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Full transaction on the CALC_CYCLES=4 instance with rsp_ready held high.
   task automatic run_one(input int id, input logic [15:0] net, input int exp_f, input string tag);
      int k;
      int lat;
      rsp_ready = 1'b1;
      req_net[id*16 +: 16] = net;
      req_valid = '0;
      req_valid[id] = 1'b1;
      #1;
      k = 0;
      while (!req_ready[id] && k < 50) begin tick(); k++; end
      chk({tag, "_grant"}, 32'(req_ready), 32'(1) << id);
      tick();                      // accept edge
      req_valid[id] = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin tick(); lat++; end
      chk({tag, "_lat"}, lat, 4);
      chk({tag, "_fnet"}, rsp_fnet, exp_f);
      chk({tag, "_id"}, 32'(rsp_id), id);
      tick();                      // handshake edge
      chk({tag, "_busy_after"}, 32'(busy), 0);
   endtask

   initial begin
      int k;
      int lat;
      int exp_order [5];
      int exp_f [5];
      logic [31:0] hold_f;
      logic [1:0]  hold_id;
      int seen;

      // Reset state
      rst = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_fnet", rsp_fnet, 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_busy", 32'(busy), 0);
      tick();
      rst = 1'b0;
      tick();

      // Single request, Net=0
      run_one(0, 16'd0, 500, "single");

      // Value sweep on requester 1
      run_one(1, 16'd1000, 750, "sw_p1000");
      run_one(1, 16'hFC18, 250, "sw_m1000");
      run_one(1, 16'h7FFF, 985, "sw_max");
      run_one(1, 16'h8000, 15, "sw_min");
      run_one(1, 16'd3000, 875, "sw_p3000");

      // Round-robin from ptr=0 with all requesters valid
      do_reset();
      exp_order = '{0, 1, 2, 3, 0};
      exp_f     = '{500, 545, 583, 615, 500};
      for (int i = 0; i < 4; i++) req_net[i*16 +: 16] = 16'(i*100);
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      #1;
      for (int n = 0; n < 5; n++) begin
         k = 0;
         while (req_ready == '0 && k < 50) begin tick(); k++; end
         chk("rr_grant", 32'(req_ready), 32'(1) << exp_order[n]);
         tick();
         lat = 0;
         while (!rsp_valid && lat < 50) begin tick(); lat++; end
         chk("rr_fnet", rsp_fnet, exp_f[n]);
         chk("rr_id", 32'(rsp_id), exp_order[n]);
         tick();
      end
      req_valid = '0;

      // Backpressure: hold response 10 cycles while requester 3 waits
      do_reset();
      rsp_ready = 1'b0;
      req_net[2*16 +: 16] = 16'd1000;
      req_net[3*16 +: 16] = 16'd0;
      req_valid = 4'b0100;
      #1;
      chk("bp_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b1000;
      lat = 0;
      while (!rsp_valid && lat < 50) begin tick(); lat++; end
      chk("bp_lat", lat, 4);
      hold_f  = rsp_fnet;
      hold_id = rsp_id;
      chk("bp_fnet", hold_f, 750);
      chk("bp_id", 32'(hold_id), 2);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("bp_valid_hold", 32'(rsp_valid), 1);
         chk("bp_fnet_hold", rsp_fnet, 750);
         chk("bp_id_hold", 32'(rsp_id), 2);
         chk("bp_no_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      tick();                      // handshake edge
      chk("bp_valid_drop", 32'(rsp_valid), 0);
      chk("bp_next_grant", 32'(req_ready), 32'h8);
      tick();
      req_valid = '0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin tick(); lat++; end
      chk("bp_next_fnet", rsp_fnet, 500);
      chk("bp_next_id", 32'(rsp_id), 3);
      tick();

      // Reset in the middle of CALC
      do_reset();
      run_one(0, 16'd1000, 750, "pre_rst");   // ptr now 1
      rsp_ready = 1'b1;
      req_net[1*16 +: 16] = 16'd3000;
      req_valid = 4'b0010;
      #1;
      chk("mr_grant", 32'(req_ready), 32'h2);
      tick();                      // accept, ptr -> 2
      req_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("mr_valid", 32'(rsp_valid), 0);
      chk("mr_fnet", rsp_fnet, 0);
      chk("mr_id", 32'(rsp_id), 0);
      chk("mr_busy", 32'(busy), 0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (rsp_valid) seen++;
      end
      chk("mr_no_rsp", seen, 0);
      req_net[0*16 +: 16] = 16'd0;
      req_net[3*16 +: 16] = 16'd0;
      req_valid = 4'b1001;
      #1;
      chk("mr_ptr0_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin tick(); lat++; end
      chk("mr_after_id", 32'(rsp_id), 0);
      tick();

      // CALC_CYCLES=1 instance; requester 1 gives up before its grant
      do_reset();
      rsp_ready1 = 1'b1;
      req_net1[0*16 +: 16] = 16'd1000;
      req_net1[1*16 +: 16] = 16'd3000;
      req_valid1 = 4'b0011;
      #1;
      chk("c1_grant", 32'(req_ready1), 32'h1);
      tick();                      // accept requester 0
      req_valid1 = 4'b0000;        // requester 1 withdraws
      chk("c1_busy", 32'(busy1), 1);
      tick();
      chk("c1_valid", 32'(rsp_valid1), 1);
      chk("c1_fnet", rsp_fnet1, 750);
      chk("c1_id", 32'(rsp_id1), 0);
      tick();
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid1 || req_ready1 != '0) seen++;
         tick();
      end
      chk("c1_dropped_none", seen, 0);
      chk("c1_idle", 32'(busy1), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
